// File: rtl/rx_sample_decimator_pkg.sv
// Shared definitions for the RX decimation path: sample/slot widths,
// the default number of downstream sample RAMs, and the FSM state encoding.
package rx_sample_decimator_pkg;

    localparam int RX_SAMPLE_W      = 16;
    localparam int RX_NUM_SLOTS_DEF = 20;
    localparam int RX_SLOT_W        = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } rx_state_e;

endpackage

// File: rtl/rx_sat_trunc.sv
// Narrows a wide signed value to one 16-bit sample. With RX_DECIM_SATURATE_EN
// defined, out-of-range values clamp and raise o_clipped; otherwise the low 16 bits pass.
module rx_sat_trunc
    import rx_sample_decimator_pkg::*;
#(
    parameter int IN_W = 18
) (
    input  logic signed [IN_W-1:0]        i_value,
    output logic signed [RX_SAMPLE_W-1:0] o_value,
    output logic                          o_clipped
);

`ifdef RX_DECIM_SATURATE_EN
    // The value fits in 16 bits exactly when every bit from 15 upward agrees with the sign.
    logic [IN_W-RX_SAMPLE_W:0] w_top;

    assign w_top     = i_value[IN_W-1:RX_SAMPLE_W-1];
    assign o_clipped = !((&w_top) || !(|w_top));
    assign o_value   = !o_clipped        ? $signed(i_value[RX_SAMPLE_W-1:0]) :
                       i_value[IN_W-1]   ? 16'sh8000 : 16'sh7FFF;
`else
    logic w_unused_hi;

    assign w_unused_hi = ^i_value;
    assign o_clipped   = 1'b0;
    assign o_value     = $signed(i_value[RX_SAMPLE_W-1:0]);
`endif

endmodule

// File: rtl/rx_sample_decimator.sv
// Sums groups of 2^DECIM_LOG2 valid ADC samples, shifts and narrows the sum, and tags each
// output with the round-robin RAM slot. Optional clamping via macro RX_DECIM_SATURATE_EN.
module rx_sample_decimator
    import rx_sample_decimator_pkg::*;
#(
    parameter int DECIM_LOG2 = 2,
    parameter int OUT_SHIFT  = DECIM_LOG2,
    parameter int NUM_SLOTS  = RX_NUM_SLOTS_DEF
) (
    input  logic                          crx_clk,
    input  logic                          rrx_rst_n,
    input  logic                          erx_en,
    input  logic signed [RX_SAMPLE_W-1:0] idata_adc,
    input  logic                          iadc_valid,
    output logic signed [RX_SAMPLE_W-1:0] odata_sample,
    output logic                          onew_sample_trig,
    output logic [RX_SLOT_W-1:0]          oslot,
    output logic                          oframe_start,
    output logic                          osat_flag,
    output rx_state_e                     odbg_state
);

    localparam int ACC_W = RX_SAMPLE_W + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [RX_SLOT_W-1:0] SLOT_LAST = RX_SLOT_W'(NUM_SLOTS - 1);

    rx_state_e                      r_state;
    rx_state_e                      w_state_nxt;
    logic                           w_active;
    logic                           w_take;
    logic                           w_done;
    logic signed [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]               r_cnt;
    logic signed [ACC_W-1:0]        w_sample_ext;
    logic signed [ACC_W-1:0]        w_sum;
    logic signed [ACC_W-1:0]        w_shifted;
    logic signed [RX_SAMPLE_W-1:0]  w_out_value;
    logic                           w_clipped;
    logic signed [RX_SAMPLE_W-1:0]  r_data;
    logic                           r_trig;
    logic                           r_frame;
    logic                           r_sat;
    logic [RX_SLOT_W-1:0]           r_slot;
    logic [RX_SLOT_W-1:0]           r_next_slot;

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Samples are taken only in ACCUM with the enable still high, so dropping
    // erx_en discards the partial group even on its completing cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (erx_en) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!erx_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_active = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // iadc_valid is a one-cycle qualifier with no backpressure: every valid cycle in ACCUM is consumed.
    assign w_take       = w_active && iadc_valid;
    assign w_done       = w_take && (r_cnt == CNT_LAST);
    assign w_sample_ext = ACC_W'(idata_adc);
    assign w_sum        = r_acc + w_sample_ext;
    assign w_shifted    = w_sum >>> OUT_SHIFT;

    rx_sat_trunc #(
        .IN_W (ACC_W)
    ) u_sat_trunc (
        .i_value   (w_shifted),
        .o_value   (w_out_value),
        .o_clipped (w_clipped)
    );

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!w_active || w_done) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_slot shows the RAM of the sample being pulsed; r_next_slot is the one the next group lands in.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_data      <= '0;
            r_trig      <= 1'b0;
            r_frame     <= 1'b0;
            r_sat       <= 1'b0;
            r_slot      <= '0;
            r_next_slot <= '0;
        end else begin
            r_trig  <= w_done;
            r_frame <= w_done && (r_next_slot == '0);
            if (w_done) begin
                r_data      <= w_out_value;
                r_slot      <= r_next_slot;
                r_next_slot <= (r_next_slot == SLOT_LAST) ? '0 : r_next_slot + 1'b1;
                if (w_clipped) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign odata_sample     = r_data;
    assign onew_sample_trig = r_trig;
    assign oslot            = r_slot;
    assign oframe_start     = r_frame;
    assign osat_flag        = r_sat;
    assign odbg_state       = r_state;

endmodule

// File: tb/tb_rx_sample_decimator.sv
// Bench for rx_sample_decimator: three configurations share one stimulus stream and are
// compared each cycle against a group-sum reference model (honours RX_DECIM_SATURATE_EN).
module tb_rx_sample_decimator;
    import rx_sample_decimator_pkg::*;

    localparam int N_DUT = 3;
    localparam int NSLOT = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic valid;
    logic [15:0] data;

    always #5 clk = ~clk;

    logic [15:0] o_data  [N_DUT];
    logic        o_trig  [N_DUT];
    logic [4:0]  o_slot  [N_DUT];
    logic        o_frame [N_DUT];
    logic        o_sat   [N_DUT];
    rx_state_e   o_dbg   [N_DUT];

    rx_sample_decimator #(.DECIM_LOG2(2), .OUT_SHIFT(2), .NUM_SLOTS(NSLOT)) dut0 (
        .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .idata_adc(data), .iadc_valid(valid),
        .odata_sample(o_data[0]), .onew_sample_trig(o_trig[0]), .oslot(o_slot[0]),
        .oframe_start(o_frame[0]), .osat_flag(o_sat[0]), .odbg_state(o_dbg[0]));

    rx_sample_decimator #(.DECIM_LOG2(2), .OUT_SHIFT(0), .NUM_SLOTS(NSLOT)) dut1 (
        .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .idata_adc(data), .iadc_valid(valid),
        .odata_sample(o_data[1]), .onew_sample_trig(o_trig[1]), .oslot(o_slot[1]),
        .oframe_start(o_frame[1]), .osat_flag(o_sat[1]), .odbg_state(o_dbg[1]));

    rx_sample_decimator #(.DECIM_LOG2(0), .OUT_SHIFT(0), .NUM_SLOTS(NSLOT)) dut2 (
        .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .idata_adc(data), .iadc_valid(valid),
        .odata_sample(o_data[2]), .onew_sample_trig(o_trig[2]), .oslot(o_slot[2]),
        .oframe_start(o_frame[2]), .osat_flag(o_sat[2]), .odbg_state(o_dbg[2]));

    function automatic int dlog_of(input int k);
        return (k == 2) ? 0 : 2;
    endfunction

    function automatic int shift_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_seen0  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q [N_DUT][$];
    longint      g_sum   [N_DUT];
    int          g_n     [N_DUT];
    bit          en_prev;
    bit          m_trig  [N_DUT];
    logic [15:0] m_data  [N_DUT];
    int          m_slot  [N_DUT];
    bit          m_frame [N_DUT];
    bit          m_sat   [N_DUT];
    int          m_ntrig [N_DUT];

    task automatic model_reset();
        en_prev = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            exp_q[k].delete();
            g_sum[k]   = 0;
            g_n[k]     = 0;
            m_trig[k]  = 1'b0;
            m_data[k]  = '0;
            m_slot[k]  = 0;
            m_frame[k] = 1'b0;
            m_sat[k]   = 1'b0;
            m_ntrig[k] = 0;
        end
    endtask

    always @(negedge rst_n) model_reset();

    // A sample counts when enable was high at the previous edge (block active) and is still high.
    always @(posedge clk) begin
        longint      sh;
        logic [15:0] res;
        bit          clip;
        if (rst_n) begin
            for (int k = 0; k < N_DUT; k++) begin
                m_trig[k]  = 1'b0;
                m_frame[k] = 1'b0;
                if (!(en_prev && en)) begin
                    g_sum[k] = 0;
                    g_n[k]   = 0;
                end else if (valid) begin
                    g_sum[k] += longint'($signed(data));
                    g_n[k]++;
                    if (g_n[k] == (1 << dlog_of(k))) begin
                        sh   = g_sum[k] >>> shift_of(k);
                        res  = sh[15:0];
                        clip = 1'b0;
`ifdef RX_DECIM_SATURATE_EN
                        if (sh > 32767) begin
                            res  = 16'h7FFF;
                            clip = 1'b1;
                        end else if (sh < -32768) begin
                            res  = 16'h8000;
                            clip = 1'b1;
                        end
`endif
                        m_trig[k]  = 1'b1;
                        m_data[k]  = res;
                        m_slot[k]  = m_ntrig[k] % NSLOT;
                        m_frame[k] = (m_slot[k] == 0);
                        m_ntrig[k]++;
                        if (clip) m_sat[k] = 1'b1;
                        exp_q[k].push_back(res);
                        g_sum[k] = 0;
                        g_n[k]   = 0;
                    end
                end
            end
            en_prev = en;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [15:0] ed;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("trig[%0d]", k), 32'(o_trig[k]), 32'(m_trig[k]));
            ed = m_data[k];
            if (m_trig[k] && exp_q[k].size() > 0) ed = exp_q[k].pop_front();
            check($sformatf("data[%0d]", k), 32'(o_data[k]), 32'(ed));
            check($sformatf("slot[%0d]", k), 32'(o_slot[k]), 32'(m_slot[k]));
            check($sformatf("frame[%0d]", k), 32'(o_frame[k]), 32'(m_frame[k]));
            check($sformatf("sat[%0d]", k), 32'(o_sat[k]), 32'(m_sat[k]));
            check($sformatf("state[%0d]", k), 32'(o_dbg[k]),
                  32'((rst_n && en_prev) ? ST_ACCUM : ST_IDLE));
        end
        if (o_trig[0]) n_seen0++;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic e, input logic v, input logic [15:0] d);
        @(negedge clk);
        en    = e;
        valid = v;
        data  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_trig",  32'(o_trig[0]),  0);
        check("rst_data",  32'(o_data[0]),  0);
        check("rst_slot",  32'(o_slot[0]),  0);
        check("rst_frame", 32'(o_frame[0]), 0);
        check("rst_sat",   32'(o_sat[0]),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 100..400 back to back: average 250 in slot 0
        drive(1, 0, 0);
        drive(1, 1, 100);
        drive(1, 1, 200);
        drive(1, 1, 300);
        drive(1, 1, 400);
        drive(1, 0, 0);
        check("avg_trig",  32'(o_trig[0]),  1);
        check("avg_data",  32'(o_data[0]),  250);
        check("avg_slot",  32'(o_slot[0]),  0);
        check("avg_frame", 32'(o_frame[0]), 1);

        // constant -3 over 21 groups, slot wraps
        for (int i = 0; i < 84; i++) drive(1, 1, 16'hFFFD);
        drive(1, 0, 0);
        check("const_data", 32'(o_data[0]), 32'(16'hFFFD));
        drive(1, 0, 0);
        check("const_ntrig", n_seen0, 22);

        // full-scale sum with no shift
        for (int i = 0; i < 4; i++) drive(1, 1, 16'h7FFF);
        drive(1, 0, 0);
        check("fs_div_data", 32'(o_data[0]), 32'(16'h7FFF));
`ifdef RX_DECIM_SATURATE_EN
        check("fs_sat_data", 32'(o_data[1]), 32'(16'h7FFF));
        check("fs_sat_flag", 32'(o_sat[1]), 1);
`else
        check("fs_wrap_data", 32'(o_data[1]), 32'(16'hFFFC));
        check("fs_wrap_flag", 32'(o_sat[1]), 0);
`endif

        // enable drops on the completing sample: group discarded
        drive(1, 1, 1);
        drive(1, 1, 1);
        drive(1, 1, 1);
        drive(0, 1, 1);
        drive(1, 0, 0);
        check("drop_last_trig", 32'(o_trig[0]), 0);

        // asynchronous reset mid-group after several triggers
        for (int i = 0; i < 22; i++) drive(1, 1, 16'($urandom));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_trig",  32'(o_trig[0]),  0);
        check("arst_data",  32'(o_data[0]),  0);
        check("arst_slot",  32'(o_slot[0]),  0);
        check("arst_frame", 32'(o_frame[0]), 0);
        check("arst_state", 32'(o_dbg[0]),   32'(ST_IDLE));
        en    = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base  = n_seen0;

        // partial group discarded by enable drop, then a fresh group of 8s
        drive(1, 0, 0);
        drive(1, 1, 77);
        drive(1, 1, 77);
        drive(0, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 8);
        drive(1, 0, 0);
        check("restart_trig",  32'(o_trig[0]),  1);
        check("restart_data",  32'(o_data[0]),  8);
        check("restart_slot",  32'(o_slot[0]),  0);
        check("restart_frame", 32'(o_frame[0]), 1);
        drive(1, 0, 0);
        check("restart_ntrig", n_seen0 - base, 1);

        // valid gaps only stall accumulation
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4);
            drive(1, 0, 0);
            check($sformatf("gap_trig%0d", i), 32'(o_trig[0]), (i == 3) ? 1 : 0);
        end
        check("gap_data", 32'(o_data[0]), 4);

        // randomized traffic with occasional enable drops and full-scale samples
        for (int i = 0; i < 3000; i++) begin
            logic        e;
            logic        v;
            logic [15:0] d;
            e = ($urandom_range(0, 24) != 0);
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            drive(e, v, d);
        end
        drive(0, 0, 0);
        drive(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_sample_decimator.md
RX_SAMPLE_DECIMATOR -- requirements
Module: rx_sample_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 2, meaning log2 of the decimation factor (legal range 0..6).
REQ-002 SHALL have parameter OUT_SHIFT, default DECIM_LOG2, meaning the arithmetic right shift applied to the group sum (legal range 0..DECIM_LOG2).
REQ-003 SHALL have parameter NUM_SLOTS, default 20, meaning the number of downstream sample RAMs cycled through.
REQ-004 crx_clk  in  1  single clock; all logic on rising edge.
REQ-005 rrx_rst_n  in  1  asynchronous, active-low reset.
REQ-006 erx_en  in  1  block enable.
REQ-007 idata_adc  in  16  signed raw input sample.
REQ-008 iadc_valid  in  1  qualifies idata_adc for one cycle; may be high every cycle.
REQ-009 odata_sample  out  16  signed decimated sample, registered.
REQ-010 onew_sample_trig  out  1  one-cycle pulse; odata_sample is valid in the same cycle.
REQ-011 oslot  out  5  index 0..NUM_SLOTS-1 of the RAM that the pulsed sample belongs to.
REQ-012 oframe_start  out  1  pulse coincident with onew_sample_trig when oslot==0.
REQ-013 osat_flag  out  1  sticky flag; set when any output was clipped.

Function
REQ-014 SHALL implement the states IDLE and ACCUM: IDLE->ACCUM when erx_en=1; any state->IDLE when erx_en=0.
REQ-015 In IDLE, SHALL hold the accumulator and group counter at 0, keep onew_sample_trig and oframe_start at 0, and hold oslot and odata_sample.
REQ-016 In ACCUM, each cycle with iadc_valid=1 SHALL add sign-extended idata_adc to a (16+DECIM_LOG2)-bit accumulator and increment the group counter, which runs 0..2^DECIM_LOG2-1.
REQ-017 On the valid sample that completes a group (counter = 2^DECIM_LOG2-1), the next clock edge SHALL register (accumulator + idata_adc) >>> OUT_SHIFT into odata_sample, assert onew_sample_trig for one cycle, and restart the accumulator from 0 with no lost sample.
REQ-018 Latency SHALL be exactly 1 cycle, from the edge that captures the last valid sample of a group to the onew_sample_trig high cycle.
REQ-019 The shift SHALL be an arithmetic shift (rounds toward minus infinity); no rounding is added.
REQ-020 With DECIM_LOG2=0, every valid input SHALL produce a trigger on the next cycle (pass-through).
REQ-021 oslot SHALL start at 0 after reset, advance by 1 after each trigger, and wrap from NUM_SLOTS-1 to 0.
REQ-022 The first trigger after reset SHALL carry oslot=0, so oslot tracks the downstream round-robin RAM counter.
REQ-023 When erx_en falls mid-group, the partial group SHALL be discarded, oslot SHALL NOT advance, and the next group SHALL start fresh.
REQ-024 If erx_en falls in the cycle that completes a group, that group SHALL be discarded and no trigger issued.
REQ-025 Gaps in iadc_valid SHALL only stall accumulation; they SHALL NOT affect the sum or reset the group.

Reset
REQ-026 While rrx_rst_n=0, SHALL asynchronously force: state=IDLE, accumulator=0, group counter=0, odata_sample=0, onew_sample_trig=0, oslot=0, oframe_start=0, osat_flag=0.
REQ-027 Reset SHALL be released synchronously by the design; the first ACCUM cycle SHALL come no earlier than the first edge after deassertion.

Configuration
REQ-028 With macro RX_DECIM_SATURATE_EN defined, a shifted result outside [-32768, 32767] SHALL clamp to the nearest bound and set osat_flag.
REQ-029 With RX_DECIM_SATURATE_EN undefined, SHALL output the low 16 bits of the shifted result (wrap), and osat_flag SHALL be tied to 0.

Structure
REQ-030 A shared rx package SHALL hold: the sample width (16), the NUM_SLOTS default (20), the slot index width (5), and the state encoding.
REQ-031 The saturation/truncation logic SHALL be a sub-module rx_sat_trunc (parameterised input width, 16-bit output).

Verification
REQ-032 DECIM_LOG2=2, OUT_SHIFT=2, inputs 100,200,300,400 valid back-to-back -> odata_sample=250 with onew_sample_trig high exactly 1 cycle after the 4th sample, oslot=0, oframe_start=1.
REQ-033 Constant input -3, factor 4, OUT_SHIFT=2 -> every output is -3; 20 triggers with oslot 0..19, then the 21st trigger has oslot=0 and oframe_start=1.
REQ-034 OUT_SHIFT=0, four samples of 32767, RX_DECIM_SATURATE_EN defined -> output 32767 and osat_flag=1; same stimulus without the macro -> output 0xFFFC (low 16 bits of the sum) and osat_flag=0.
REQ-035 erx_en dropped after 2 of 4 samples, then re-enabled with 4 samples of 8 -> only one trigger, value 8, oslot=0.
REQ-036 iadc_valid toggling 1,0,1,0,... with values 4,4,4,4 -> one trigger of value 4, issued 1 cycle after the 4th valid sample.
REQ-037 rrx_rst_n asserted mid-group after 5 triggers -> all outputs 0 immediately (asynchronous); after release the first trigger has oslot=0.
